fetch_queue: RTL and testbench

Instruction fetch unit with a small prefetch queue, sitting directly upstream of the RV32 datapath. It issues word requests to instruction memory over a req/ack handshake and buffers returned instructions with their PCs. It hands them to the datapath over a valid/ready interface, and flushes and re-steers on a redirect (branch/jump) from the datapath.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues word requests over req/ack and buffers returned
// instructions with their PCs in a small circular prefetch queue.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [31:0]     mem_instr [DEPTH];
  logic [31:0]     mem_pc    [DEPTH];

  logic            enq;
  logic            deq;
  logic            ack_any;
  logic            room;
  logic [CW-1:0]   cnt_nxt;
  logic [31:0]     new_pc;

  always_comb begin
    deq_valid = (count != '0);
    enq       = (state == REQ) && imem_ack;
    deq       = deq_valid && deq_ready;
    ack_any   = (state != IDLE) && imem_ack;
    cnt_nxt   = count + CW'(enq) - CW'(deq);
    // Only issue when the outstanding word is guaranteed a free slot on ack.
    room      = (cnt_nxt < CW'(DEPTH));
    new_pc    = {redirect_pc[31:2], 2'b00};
    deq_instr = deq_valid ? mem_instr[head] : 32'h0000_0013;
    deq_pc    = deq_valid ? mem_pc[head] : '0;
  end

  always_ff @(posedge clk) begin
    if (enq && !redirect) begin
      mem_instr[tail] <= imem_rdata;
      mem_pc[tail]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= new_pc;
      // A request still in flight must complete before re-steering.
      if (state == IDLE || ack_any) begin
        state     <= REQ;
        imem_req  <= 1'b1;
        imem_addr <= new_pc;
      end else begin
        state <= DRAIN;
      end
    end else begin
      count <= cnt_nxt;
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case (state)
        IDLE: begin
          if (room) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (room) begin
              imem_addr <= fetch_pc + 32'd4;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state     <= REQ;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue, checked against a transaction-level
// model: a queue of {pc, instr} plus one outstanding-request record.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  bit          busy;
  bit          stale;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy   = 0;
    stale  = 0;
    m_addr = RPC;
    m_pc   = RPC;
  endtask

  // Reference behaviour at one rising edge, from the inputs held during the cycle.
  task automatic model_step();
    bit acked;
    acked = busy && imem_ack;
    if (redirect) begin
      q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (!busy || acked) begin
        busy   = 1;
        stale  = 0;
        m_addr = m_pc;
      end else begin
        stale = 1;
      end
    end else begin
      if (q.size() > 0 && deq_ready) void'(q.pop_front());
      if (acked) begin
        if (!stale) begin
          q.push_back('{pc: m_addr, instr: imem_rdata});
          m_pc = m_pc + 32'd4;
        end
        busy  = 0;
        stale = 0;
      end
      if (!busy && q.size() < DEPTH) begin
        busy   = 1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(busy));
    chk("imem_addr", imem_addr, m_addr);
    chk("count", 32'(count), 32'(q.size()));
    chk("deq_valid", 32'(deq_valid), 32'(q.size() > 0));
    chk("deq_pc", deq_pc, (q.size() > 0) ? q[0].pc : 32'h0);
    chk("deq_instr", deq_instr, (q.size() > 0) ? q[0].instr : 32'h0000_0013);
  endtask

  task automatic cyc(input bit ack, input bit rdy, input bit rd, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = $urandom;
    deq_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; deq_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Streaming: ack every cycle, consumer always ready.
    cyc(0, 1, 0, 0);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
    chk("stream_valid", 32'(deq_valid), 32'd1);

    // Fill with consumer stalled, then free one slot.
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_noreq", 32'(imem_req), 32'd0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("refill_req", 32'(imem_req), 32'd1);
    cyc(1, 0, 0, 0);
    chk("refill_count", 32'(count), 32'd4);

    // Drain queue with a request pending, then redirect mid-request.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h0000_0102);
    chk("drain_count", 32'(count), 32'd0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("drain_newaddr", imem_addr, 32'h0000_0100);
    chk("drain_noenq", 32'(count), 32'd0);

    // Redirect coinciding with an ack.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h0000_0200);
    chk("redir_ack_addr", imem_addr, 32'h0000_0200);
    chk("redir_ack_req", 32'(imem_req), 32'd1);

    // Steady state at count=2 with simultaneous enqueue and dequeue.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0);
      chk("steady_count", 32'(count), 32'd2);
    end

    // Reset while a request is outstanding; a late ack is ignored.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    imem_ack = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc(1, 1, 0, 0);
    chk("post_rst_addr", imem_addr, RPC);
    cyc(1, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 11) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
